// File: rtl/aes_pkg.sv
// Shared AES definitions for the MixColumns engine.
//   AES_COL_W : width of one AES state column (4 bytes).
//   fsm_t     : engine control states.
//   xtime     : multiply by x (0x02) in GF(2^8) with the AES polynomial.
//   col_lsb   : LSB position of column idx in a packed state of ncol
//               columns (column 0 sits in the most significant word).
package aes_pkg;

    localparam int AES_COL_W = 32;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        RUN  = 2'd1,
        DONE = 2'd2
    } fsm_t;

    function automatic logic [7:0] xtime(input logic [7:0] a);
        return {a[6:0], 1'b0} ^ (a[7] ? 8'h1b : 8'h00);
    endfunction

    function automatic int col_lsb(input int ncol, input int idx);
        return (ncol - 1 - idx) * AES_COL_W;
    endfunction

endpackage

// File: rtl/mix_col_unit.sv
// Combinational single-column MixColumns / InvMixColumns unit.
//   inv : 0 = forward MixColumns, 1 = InvMixColumns
//   col : input column, byte 0 in bits [31:24]
//   res : transformed column, same byte order
// The inverse is computed as a preprocessing step that folds
// 4*(a0^a2) and 4*(a1^a3) into the bytes, followed by the forward
// transform, so the forward datapath is shared by both modes.
module mix_col_unit
    import aes_pkg::*;
(
    input  logic                 inv,
    input  logic [AES_COL_W-1:0] col,
    output logic [AES_COL_W-1:0] res
);

    logic [7:0] a0, a1, a2, a3;
    logic [7:0] u, v;
    logic [7:0] p0, p1, p2, p3;
    logic [7:0] t;

    always_comb begin
        a0 = col[31:24];
        a1 = col[23:16];
        a2 = col[15:8];
        a3 = col[7:0];

        // u/v vanish in forward mode, leaving the bytes untouched
        u = inv ? xtime(xtime(a0 ^ a2)) : 8'h00;
        v = inv ? xtime(xtime(a1 ^ a3)) : 8'h00;
        p0 = a0 ^ u;
        p1 = a1 ^ v;
        p2 = a2 ^ u;
        p3 = a3 ^ v;

        t = p0 ^ p1 ^ p2 ^ p3;
        res[31:24] = p0 ^ t ^ xtime(p0 ^ p1);
        res[23:16] = p1 ^ t ^ xtime(p1 ^ p2);
        res[15:8]  = p2 ^ t ^ xtime(p2 ^ p3);
        res[7:0]   = p3 ^ t ^ xtime(p3 ^ p0);
    end

endmodule

// File: rtl/mix_columns_seq.sv
// Column-serial MixColumns engine: one AES state per handshake, one
// column per cycle through a single shared column unit, result held
// on a valid/ready output.
//   clk, rst_n         : clock, async active-low reset
//   flush              : synchronous abort back to IDLE
//   in_valid/in_ready  : input handshake; in_inv and in_data sampled
//                        only on the accept cycle
//   out_valid/out_ready: output handshake; out_data stable while valid
//   busy               : block in flight (RUN or DONE)
module mix_columns_seq
    import aes_pkg::*;
#(
    parameter int NCOL = 4
) (
    input  logic                      clk,
    input  logic                      rst_n,
    input  logic                      flush,
    input  logic                      in_valid,
    output logic                      in_ready,
    input  logic                      in_inv,
    input  logic [AES_COL_W*NCOL-1:0] in_data,
    output logic                      out_valid,
    input  logic                      out_ready,
    output logic [AES_COL_W*NCOL-1:0] out_data,
    output logic                      busy
);

    localparam int W  = AES_COL_W * NCOL;
    localparam int CW = (NCOL > 1) ? $clog2(NCOL) : 1;
    localparam logic [CW-1:0] LAST = CW'(NCOL - 1);

    fsm_t                 state, state_nxt;
    logic [CW-1:0]        col_cnt;
    logic                 mode_r;
    logic [W-1:0]         st;
    logic [AES_COL_W-1:0] col_in, col_out;
    logic                 accept;
    logic                 last_col;

    // Column mux: the unit always looks at the column being worked on
    assign col_in   = st[col_lsb(NCOL, int'(col_cnt)) +: AES_COL_W];
    assign last_col = (col_cnt == LAST);

    mix_col_unit u_col (
        .inv (mode_r),
        .col (col_in),
        .res (col_out)
    );

    // Handshake outputs decode the state register only
    assign in_ready  = (state == IDLE);
    assign out_valid = (state == DONE);
    assign busy      = (state != IDLE);
    assign out_data  = st;

    assign accept = (state == IDLE) && in_valid && !flush;

    always_comb begin
        state_nxt = state;
        case (state)
            IDLE:    if (in_valid)  state_nxt = RUN;
            RUN:     if (last_col)  state_nxt = DONE;
            DONE:    if (out_ready) state_nxt = IDLE;
            default:                state_nxt = IDLE;
        endcase
        if (flush) state_nxt = IDLE;
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state   <= IDLE;
            col_cnt <= '0;
            mode_r  <= 1'b0;
            st      <= '0;
        end else begin
            state <= state_nxt;
            if (flush) begin
                // state register contents are left as-is
                col_cnt <= '0;
            end else if (accept) begin
                st      <= in_data;
                mode_r  <= in_inv;
                col_cnt <= '0;
            end else if (state == RUN) begin
                // Column demux: write the result back in place
                st[col_lsb(NCOL, int'(col_cnt)) +: AES_COL_W] <= col_out;
                col_cnt <= last_col ? '0 : col_cnt + CW'(1);
            end
        end
    end

endmodule

// File: tb/tb_mix_columns_seq.sv
// Self-checking bench for mix_columns_seq (NCOL=4). The reference model
// evaluates the AES MixColumns matrices directly with a generic GF(2^8)
// multiply.
module tb_mix_columns_seq;

    logic         clk = 1'b0;
    logic         rst_n = 1'b0;
    logic         flush = 1'b0;
    logic         in_valid = 1'b0;
    logic         in_ready;
    logic         in_inv = 1'b0;
    logic [127:0] in_data = '0;
    logic         out_valid;
    logic         out_ready = 1'b0;
    logic [127:0] out_data;
    logic         busy;

    int total = 0;
    int bad   = 0;

    always #5 clk = ~clk;

    mix_columns_seq #(.NCOL(4)) dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .flush     (flush),
        .in_valid  (in_valid),
        .in_ready  (in_ready),
        .in_inv    (in_inv),
        .in_data   (in_data),
        .out_valid (out_valid),
        .out_ready (out_ready),
        .out_data  (out_data),
        .busy      (busy)
    );

    function automatic logic [7:0] gmul(input logic [7:0] a, input logic [7:0] b);
        logic [7:0] p = 8'h00;
        logic [7:0] x = a;
        for (int i = 0; i < 8; i++) begin
            if (b[i]) p = p ^ x;
            x = x[7] ? ((x << 1) ^ 8'h1b) : (x << 1);
        end
        return p;
    endfunction

    // Circulant matrix rows: forward {2,3,1,1}, inverse {e,b,d,9}
    function automatic logic [127:0] ref_mix(input logic [127:0] d, input bit inv);
        logic [7:0]   coef [4];
        logic [7:0]   a [4];
        logic [7:0]   b;
        logic [127:0] r = '0;
        if (inv) coef = '{8'h0e, 8'h0b, 8'h0d, 8'h09};
        else     coef = '{8'h02, 8'h03, 8'h01, 8'h01};
        for (int c = 0; c < 4; c++) begin
            for (int k = 0; k < 4; k++) a[k] = d[127 - 32*c - 8*k -: 8];
            for (int rr = 0; rr < 4; rr++) begin
                b = 8'h00;
                for (int k = 0; k < 4; k++) b = b ^ gmul(coef[(k - rr + 4) % 4], a[k]);
                r[127 - 32*c - 8*rr -: 8] = b;
            end
        end
        return r;
    endfunction

    task automatic chk(input string tag, input logic [127:0] obs, input logic [127:0] exp);
        total++;
        assert (obs === exp) else begin
            bad++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // Send one block, wait for out_valid (bounded), check latency and
    // data, then complete the handshake. Inputs are scrambled mid-block.
    task automatic run_block(input string tag, input logic [127:0] d, input bit inv,
                             input logic [127:0] exp);
        int n;
        chk({tag, "_in_ready"}, {127'd0, in_ready}, 128'd1);
        in_valid = 1'b1;
        in_data  = d;
        in_inv   = inv;
        tick();
        in_valid = 1'b0;
        in_data  = {$urandom, $urandom, $urandom, $urandom};
        in_inv   = $urandom_range(0, 1);
        n = 0;
        while (!out_valid && n < 20) begin
            tick();
            n++;
        end
        chk({tag, "_latency"}, 128'(n), 128'd4);
        chk({tag, "_data"}, out_data, exp);
        out_ready = 1'b1;
        tick();
        out_ready = 1'b0;
        chk({tag, "_idle_after"}, {126'd0, in_ready, out_valid}, {126'd0, 2'b10});
    endtask

    localparam logic [127:0] V_A = 128'hdb135345_f20a225c_01010101_c6c6c6c6;
    localparam logic [127:0] V_B = 128'h8e4da1bc_9fdc589d_01010101_c6c6c6c6;
    localparam logic [127:0] V_C = 128'hd4d4d4d5_2d26314c_01010101_c6c6c6c6;
    localparam logic [127:0] V_D = 128'hd5d5d7d6_4d7ebdf8_01010101_c6c6c6c6;

    initial begin
        logic [127:0] held, d;
        logic [127:0] bd [3];
        bit           bm [3];
        bit           m, rdy_seen, stable, ov_seen, acc, hs;
        int           acc_t [$];
        int           idx_in, outs, t;

        // Reset state
        #13;
        chk("reset_outputs", {124'd0, in_ready, out_valid, busy, 1'b0}, {124'd0, 4'b1000});
        chk("reset_data", out_data, '0);
        rst_n = 1'b1;
        tick();

        // Known vectors, both directions, checked against constants and model
        chk("model_fwd", ref_mix(V_A, 1'b0), V_B);
        run_block("fips_fwd", V_A, 1'b0, V_B);
        run_block("fips_inv", V_B, 1'b1, V_A);
        run_block("vec2_fwd", V_C, 1'b0, V_D);

        // Backpressure: hold result for 10 cycles
        in_valid = 1'b1; in_data = V_C; in_inv = 1'b0;
        tick();
        in_valid = 1'b0;
        for (int i = 0; i < 4; i++) tick();
        held = out_data;
        rdy_seen = 1'b0; stable = 1'b1;
        for (int i = 0; i < 10; i++) begin
            tick();
            if (in_ready) rdy_seen = 1'b1;
            if (out_data !== held || !out_valid) stable = 1'b0;
        end
        chk("bp_in_ready_low", {127'd0, rdy_seen}, 128'd0);
        chk("bp_stable", {127'd0, stable}, 128'd1);
        chk("bp_data", held, V_D);
        out_ready = 1'b1;
        tick();
        out_ready = 1'b0;
        chk("bp_release", {126'd0, in_ready, out_valid}, {126'd0, 2'b10});

        // Back-to-back, modes 0,1,0
        for (int i = 0; i < 3; i++) begin
            bd[i] = {$urandom, $urandom, $urandom, $urandom};
            bm[i] = (i == 1);
        end
        idx_in = 0; outs = 0; t = 0;
        in_valid = 1'b1; in_data = bd[0]; in_inv = bm[0]; out_ready = 1'b1;
        while (outs < 3 && t < 60) begin
            acc = in_valid && in_ready;
            hs  = out_valid && out_ready;
            held = out_data;
            tick();
            t++;
            if (acc) begin
                acc_t.push_back(t);
                idx_in++;
                if (idx_in < 3) begin
                    in_data = bd[idx_in];
                    in_inv  = bm[idx_in];
                end else begin
                    in_valid = 1'b0;
                end
            end
            if (hs) begin
                chk($sformatf("b2b_data%0d", outs), held, ref_mix(bd[outs], bm[outs]));
                outs++;
            end
        end
        in_valid = 1'b0; out_ready = 1'b0;
        chk("b2b_count", 128'(outs), 128'd3);
        if (acc_t.size() == 3) begin
            chk("b2b_gap01", 128'(acc_t[1] - acc_t[0]), 128'd6);
            chk("b2b_gap12", 128'(acc_t[2] - acc_t[1]), 128'd6);
        end else begin
            chk("b2b_accepts", 128'(acc_t.size()), 128'd3);
        end

        // Flush after column 1 written, with in_valid in the same cycle
        in_valid = 1'b1; in_data = V_A; in_inv = 1'b0;
        tick();
        in_data = V_B;
        tick();
        tick();
        flush = 1'b1;
        tick();
        flush = 1'b0; in_valid = 1'b0;
        chk("flush_idle", {125'd0, in_ready, out_valid, busy}, {125'd0, 3'b100});
        ov_seen = 1'b0;
        for (int i = 0; i < 8; i++) begin
            tick();
            if (out_valid || busy) ov_seen = 1'b1;
        end
        chk("flush_no_output", {127'd0, ov_seen}, 128'd0);
        run_block("post_flush", V_C, 1'b0, V_D);

        // Asynchronous reset mid-RUN
        in_valid = 1'b1; in_data = V_B; in_inv = 1'b1;
        tick();
        in_valid = 1'b0;
        tick();
        #2 rst_n = 1'b0;
        #1;
        chk("arst_outputs", {125'd0, in_ready, out_valid, busy}, {125'd0, 3'b100});
        chk("arst_data", out_data, '0);
        #2 rst_n = 1'b1;
        tick();
        run_block("post_rst", V_A, 1'b0, V_B);

        // Random blocks and modes against the model
        for (int i = 0; i < 8; i++) begin
            d = {$urandom, $urandom, $urandom, $urandom};
            m = $urandom_range(0, 1);
            run_block($sformatf("rand%0d", i), d, m, ref_mix(d, m));
        end

        // Inverse must undo forward on random data
        d = {$urandom, $urandom, $urandom, $urandom};
        run_block("rt_fwd", d, 1'b0, ref_mix(d, 1'b0));
        run_block("rt_inv", ref_mix(d, 1'b0), 1'b1, d);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule

// File: doc/mix_columns_seq.md
# mix_columns_seq

Column-serial MixColumns engine for the AES round datapath. It accepts one 128-bit AES state per handshake and drives a single shared 32-bit column unit once per column, one column per cycle. It returns the mixed state through a valid/ready output. Forward and inverse MixColumns are selected per block, so one engine serves both encrypt and decrypt round pipelines in place of four parallel column instances.

## Interface
Parameters:
- NCOL, default 4: number of 32-bit columns per block; block width is 32*NCOL; column counter width is clog2(NCOL), minimum 1.

Ports:
- clk  input  1  rising-edge clock; single clock domain.
- rst_n  input  1  asynchronous, active-low reset.
- flush  input  1  synchronous abort; returns the block to IDLE.
- in_valid  input  1  input block present.
- in_ready  output  1  engine can accept a block.
- in_inv  input  1  mode, sampled at accept: 0 = MixColumns, 1 = InvMixColumns.
- in_data  input  32*NCOL  AES state; column 0 = bits [32*NCOL-1 : 32*NCOL-32], byte 0 of a column = its MSB byte.
- out_valid  output  1  result block present.
- out_ready  input  1  consumer accepts the result.
- out_data  output  32*NCOL  mixed state, same packing as in_data.
- busy  output  1  high in RUN or DONE.

## Operation
- FSM states:
  - IDLE: in_ready=1; in_valid&&in_ready loads in_data into the state register, latches in_inv into mode_r, clears col_cnt, and moves to RUN.
  - RUN: each cycle, column col_cnt of the state register passes through the column unit; the result overwrites that column in place; col_cnt increments. When col_cnt==NCOL-1 the FSM moves to DONE, and col_cnt wraps to 0.
  - DONE: out_valid=1 and out_data = the state register. out_valid&&out_ready moves to IDLE.
- Column unit, forward (mode_r=0): standard AES MixColumns. For a column a0..a3, t = a0^a1^a2^a3 and bi = ai ^ t ^ xtime(ai ^ a(i+1 mod 4)).
  - xtime(a) = (a<<1) truncated to 8 bits, then ^8'h1b when a[7]=1.
- Column unit, inverse (mode_r=1): a preprocessing step followed by the forward transform.
  - Preprocess: u = xtime(xtime(a0^a2)), v = xtime(xtime(a1^a3)); a0'=a0^u, a1'=a1^v, a2'=a2^u, a3'=a3^v.
- No overlap: in_ready=0 in RUN and DONE. A new block is accepted only in IDLE, so the earliest is the cycle after the DONE handshake.
- flush has priority over every other event in any state:
  - next state IDLE, col_cnt=0, out_valid=0;
  - the state register holds its contents (don't-care);
  - an in_valid in the same cycle as flush is not accepted.
- in_inv and in_data are ignored outside the accept cycle. Changing them mid-block has no effect.
- Reset, asynchronous, rst_n=0: state=IDLE, col_cnt=0, mode_r=0, state register=0, out_valid=0, busy=0, in_ready=1 (combinational from IDLE). Reset mid-block discards the block.

## Timing
- Accept at edge E0. Columns are written at edges E1..E(NCOL). out_valid rises after edge E(NCOL): 4 cycles accept-to-valid for NCOL=4.
- out_valid is registered and stays high, with out_data stable, until the out_ready handshake.
- Throughput: with out_ready held high, one block per NCOL+2 cycles (6 for NCOL=4).
- in_ready is combinational from the state register only, never from in_valid.
- out_ready has no combinational path to in_ready.
- Column unit: one combinational path per cycle from the state register through the unit and back to the state register (worst case, inverse: 4 xtime + ~6 XOR levels).

## Structure
- Shared package aes_pkg holds:
  - the xtime function;
  - the column-slice helper;
  - the FSM state typedef (IDLE/RUN/DONE);
  - the AES_COL_W=32 constant.
- One sub-module, mix_col_unit: 32-bit in/out plus an inv select. It is purely combinational and wraps the preprocessing step and the forward column transform.
- The top level holds the FSM, col_cnt, mode_r, the state register, and the column mux/demux.

## Test plan
- Forward FIPS-197 vector: in_data=db135345_f20a225c_01010101_c6c6c6c6, in_inv=0 → out_data=8e4da1bc_9fdc589d_01010101_c6c6c6c6, with out_valid exactly 4 cycles after accept.
- Inverse round trip: in_data=8e4da1bc_9fdc589d_01010101_c6c6c6c6, in_inv=1 → out_data=db135345_f20a225c_01010101_c6c6c6c6. Also d4d4d4d5_2d26314c_… forward → d5d5d7d6_4d7ebdf8_….
- Backpressure: hold out_ready=0 for 10 cycles after out_valid → out_data stable, in_ready=0 throughout. Release → handshake, then in_ready=1 the next cycle.
- Back-to-back: in_valid and out_ready held high with 3 blocks → accepts spaced exactly 6 cycles apart; results in order; modes latched per block (0,1,0).
- flush during RUN (after column 1 is written), with in_valid=1 in the same cycle → next cycle IDLE, out_valid never asserted, block not accepted. The next block then completes correctly.
- rst_n pulsed low mid-RUN, asynchronous to clk → outputs go to reset values immediately; after release a fresh forward vector yields the correct result.
